// File: rtl/imem_responder.sv
// Instruction-fetch responder: reads an internal word memory in the accept cycle,
// carries each result through a fixed-latency pipe, and returns it in order from a response queue.
module imem_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic [31:0] Req_Addr,
  input  logic        Flush,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_Instr,
  output logic [31:0] Resp_Addr,
  output logic        Resp_Fault,
  input  logic        Wr_En,
  input  logic [31:0] Wr_Addr,
  input  logic [31:0] Wr_Data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(QUEUE_DEPTH);

  logic [31:0] mem [MEM_WORDS];

  logic          accept;
  logic          pop;
  logic          push;
  logic          req_fault;
  logic          wr_hit;
  logic          unused_wr_lsb;
  logic [31:0]   rd_instr;
  logic [CW-1:0] outstanding;

  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_fault;
  logic [31:0]        pipe_instr [LATENCY];
  logic [31:0]        pipe_addr  [LATENCY];

  logic [QUEUE_DEPTH-1:0] q_fault;
  logic [31:0]            q_instr [QUEUE_DEPTH];
  logic [31:0]            q_addr  [QUEUE_DEPTH];
  logic [PW:0]            wr_ptr;
  logic [PW:0]            rd_ptr;

  assign req_fault = (Req_Addr[1:0] != 2'b00) ||
                     ({2'b00, Req_Addr[31:2]} >= 32'(MEM_WORDS));
  assign rd_instr  = req_fault ? NOP : mem[Req_Addr[AW+1:2]];

  assign wr_hit        = Wr_En && ({2'b00, Wr_Addr[31:2]} < 32'(MEM_WORDS));
  assign unused_wr_lsb = ^Wr_Addr[1:0];

  assign Req_Ready  = (outstanding < CNT_MAX) && !Flush;
  assign accept     = Req_Valid && Req_Ready;
  assign Resp_Valid = (wr_ptr != rd_ptr);
  assign pop        = Resp_Valid && Resp_Ready && !Flush;
  assign push       = pipe_vld[LATENCY-1];

  assign Resp_Instr = Resp_Valid ? q_instr[rd_ptr[PW-1:0]] : 32'h0;
  assign Resp_Addr  = Resp_Valid ? q_addr[rd_ptr[PW-1:0]]  : 32'h0;
  assign Resp_Fault = Resp_Valid && q_fault[rd_ptr[PW-1:0]];

  // Write lands at the edge, so a read in the same cycle still sees the old word.
  always_ff @(posedge CLK) begin
    if (wr_hit) mem[Wr_Addr[AW+1:2]] <= Wr_Data;
  end

  always_ff @(posedge CLK) begin
    pipe_instr[0] <= rd_instr;
    pipe_addr[0]  <= Req_Addr;
    pipe_fault[0] <= req_fault;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_instr[i] <= pipe_instr[i-1];
      pipe_addr[i]  <= pipe_addr[i-1];
      pipe_fault[i] <= pipe_fault[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_vld <= '0;
    end else if (Flush) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Outstanding never exceeds the queue depth, so a push always finds a free slot.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_instr[wr_ptr[PW-1:0]] <= pipe_instr[LATENCY-1];
      q_addr[wr_ptr[PW-1:0]]  <= pipe_addr[LATENCY-1];
      q_fault[wr_ptr[PW-1:0]] <= pipe_fault[LATENCY-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else if (Flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (accept && !pop)      outstanding <= outstanding + CNT_ONE;
      else if (pop && !accept) outstanding <= outstanding - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of accepted fetches.
module tb_imem_responder;
  localparam int LAT = 2;
  localparam int QD  = 4;
  localparam int MW  = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic [31:0] Req_Addr = 32'h0;
  logic        Flush = 1'b0;
  logic        Resp_Valid;
  logic        Resp_Ready = 1'b0;
  logic [31:0] Resp_Instr;
  logic [31:0] Resp_Addr;
  logic        Resp_Fault;
  logic        Wr_En = 1'b0;
  logic [31:0] Wr_Addr = 32'h0;
  logic [31:0] Wr_Data = 32'h0;

  imem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Addr(Req_Addr),
    .Flush(Flush),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Instr(Resp_Instr),
    .Resp_Addr(Resp_Addr), .Resp_Fault(Resp_Fault),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
    int          rdy;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mem_m [MW];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic ent_t make_ent(input logic [31:0] a, input int rdy);
    ent_t e;
    e.addr  = a;
    e.fault = (a % 32'd4 != 32'd0) || (a / 32'd4 >= 32'(MW));
    e.instr = e.fault ? NOP : mem_m[a[11:2]];
    e.rdy   = rdy;
    return e;
  endfunction

  function automatic bit m_ready();
    return (exp_q.size() < QD) && !Flush;
  endfunction

  function automatic bit m_valid();
    return (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
  endfunction

  function automatic logic [65:0] m_resp();
    if (m_valid()) return {1'b1, exp_q[0].fault, exp_q[0].addr, exp_q[0].instr};
    return 66'h0;
  endfunction

  // Advance one clock, applying the handshakes the model predicts for the current inputs.
  task automatic tick();
    bit   acc;
    bit   pop;
    ent_t e;
    acc = Req_Valid && m_ready();
    pop = m_valid() && Resp_Ready && !Flush;
    e   = make_ent(Req_Addr, cyc + 1 + LAT);
    if (Wr_En && Wr_Addr < 32'(4 * MW)) mem_m[Wr_Addr[11:2]] = Wr_Data;
    @(posedge CLK);
    cyc++;
    if (!RST_N || Flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.delete();
    n_tests++;
    if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr});
    end
    RST_N = 1'b1;
    #1;
    n_tests++;
    if (Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b expected 1", Req_Ready);
    end
    tick();
  endtask

  task automatic load_words();
    for (int i = 0; i < 16; i++) begin
      Wr_En   = 1'b1;
      Wr_Addr = 32'(i) << 2;
      Wr_Data = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h0010_0113 : $urandom;
      tick();
    end
    Wr_En = 1'b0;
  endtask

  task automatic test_fetch_basic();
    int n0;
    Resp_Ready = 1'b1;
    Req_Valid  = 1'b1;
    Req_Addr   = 32'h0;
    #1;
    n_tests++;
    if (Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b expected 1", Req_Ready);
    end
    tick();
    n0 = cyc;
    Req_Addr = 32'h4;
    tick();
    Req_Valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [65:0] expv;
      #1;
      if (cyc == n0 + 2)      expv = {1'b1, 1'b0, 32'h0, 32'h0050_0093};
      else if (cyc == n0 + 3) expv = {1'b1, 1'b0, 32'h4, 32'h0010_0113};
      else                    expv = 66'h0;
      n_tests++;
      if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== expv) begin
        n_fail++;
        $display("FAIL basic_resp cycle %0d: got %h expected %h", cyc - n0,
                 {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr}, expv);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    Resp_Ready = 1'b0;
    Req_Valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Req_Addr = 32'(acc) << 2;
      #1;
      n_tests++;
      if (Req_Ready !== (i < QD)) begin
        n_fail++;
        $display("FAIL bp_ready step %0d: got %b expected %b", i, Req_Ready, (i < QD));
      end
      if (Req_Ready === 1'b1) acc++;
      tick();
    end
    Req_Valid = 1'b0;
    n_tests++;
    if (acc !== QD) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d expected %0d", acc, QD);
    end
    Resp_Ready = 1'b1;
    for (int i = 0; i < QD; i++) begin
      #1;
      n_tests++;
      if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== {1'b1, 1'b0, 32'(i) << 2, mem_m[i]}) begin
        n_fail++;
        $display("FAIL bp_drain %0d: got %h expected %h", i, {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr},
                 {1'b1, 1'b0, 32'(i) << 2, mem_m[i]});
      end
      n_tests++;
      if (Req_Ready !== (i != 0)) begin
        n_fail++;
        $display("FAIL bp_ready_after_pop %0d: got %b expected %b", i, Req_Ready, (i != 0));
      end
      tick();
    end
    #1;
    n_tests++;
    if (Resp_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got %b expected 0", Resp_Valid);
    end
  endtask

  task automatic test_fault();
    int seen;
    seen = 0;
    Resp_Ready = 1'b1;
    Req_Valid  = 1'b1;
    Req_Addr   = 32'h2;
    tick();
    Req_Addr = 32'h1000;
    tick();
    Req_Valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++;
      if (Resp_Valid !== m_valid()) begin
        n_fail++;
        $display("FAIL fault_valid: got %b expected %b", Resp_Valid, m_valid());
      end
      if (Resp_Valid === 1'b1) begin
        n_tests++;
        if ({Resp_Fault, Resp_Instr, Resp_Addr} !== {1'b1, NOP, (seen == 0) ? 32'h2 : 32'h1000}) begin
          n_fail++;
          $display("FAIL fault_resp %0d: got %h expected %h", seen, {Resp_Fault, Resp_Instr, Resp_Addr},
                   {1'b1, NOP, (seen == 0) ? 32'h2 : 32'h1000});
        end
        seen++;
      end
      tick();
    end
    n_tests++;
    if (seen !== 2) begin
      n_fail++;
      $display("FAIL fault_count: got %0d expected 2", seen);
    end
  endtask

  task automatic test_flush();
    int n;
    Resp_Ready = 1'b1;
    Req_Valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Req_Addr = 32'h10 + (32'(i) << 2);
      tick();
    end
    Flush    = 1'b1;
    Req_Addr = 32'h1C;
    #1;
    n_tests++;
    if (Req_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 0", Req_Ready);
    end
    tick();
    Flush     = 1'b0;
    Req_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (Resp_Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale %0d: got %b expected 0", i, Resp_Valid);
      end
      tick();
    end
    Req_Valid = 1'b1;
    Req_Addr  = 32'h8;
    tick();
    n = cyc;
    Req_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [65:0] expv;
      #1;
      expv = (cyc == n + 2) ? {1'b1, 1'b0, 32'h8, mem_m[2]} : 66'h0;
      n_tests++;
      if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== expv) begin
        n_fail++;
        $display("FAIL flush_refetch cycle %0d: got %h expected %h", cyc - n,
                 {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr}, expv);
      end
      tick();
    end
  endtask

  task automatic test_write_collision();
    logic [31:0] old_w;
    int n;
    old_w      = mem_m[3];
    Resp_Ready = 1'b1;
    Req_Valid  = 1'b1;
    Req_Addr   = 32'hC;
    Wr_En      = 1'b1;
    Wr_Addr    = 32'hC;
    Wr_Data    = 32'hDEAD_BEEF;
    tick();
    n = cyc;
    Wr_En = 1'b0;
    tick();
    Req_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [65:0] expv;
      #1;
      if (cyc == n + 2)      expv = {1'b1, 1'b0, 32'hC, old_w};
      else if (cyc == n + 3) expv = {1'b1, 1'b0, 32'hC, 32'hDEAD_BEEF};
      else                   expv = 66'h0;
      n_tests++;
      if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== expv) begin
        n_fail++;
        $display("FAIL wr_collision cycle %0d: got %h expected %h", cyc - n,
                 {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr}, expv);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    Resp_Ready = 1'b0;
    Req_Valid  = 1'b1;
    Req_Addr   = 32'h0;
    tick();
    Req_Addr = 32'h4;
    tick();
    Req_Valid = 1'b0;
    tick();
    tick();
    #1;
    n_tests++;
    if ({Resp_Valid, Req_Ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre: got %b expected 11", {Resp_Valid, Req_Ready});
    end
    #1 RST_N = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== 66'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected 0", {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr});
    end
    tick();
    tick();
    RST_N = 1'b1;
    #1;
    n_tests++;
    if (Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release_ready: got %b expected 1", Req_Ready);
    end
    Resp_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (Resp_Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale %0d: got %b expected 0", i, Resp_Valid);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      Req_Valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 8)       Req_Addr = 32'($urandom_range(0, 15)) << 2;
      else if (r == 8) Req_Addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else             Req_Addr = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
      Resp_Ready = (i % 100 < 50) ? 1'b1 : ($urandom_range(0, 2) != 0);
      Flush      = ($urandom_range(0, 24) == 0);
      Wr_En      = ($urandom_range(0, 7) == 0);
      Wr_Addr    = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      Wr_Data    = $urandom;
      #1;
      n_tests++;
      if (Req_Ready !== m_ready()) begin
        n_fail++;
        $display("FAIL rand_ready step %0d: got %b expected %b", i, Req_Ready, m_ready());
      end
      n_tests++;
      if ({Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr} !== m_resp()) begin
        n_fail++;
        $display("FAIL rand_resp step %0d: got %h expected %h", i,
                 {Resp_Valid, Resp_Fault, Resp_Addr, Resp_Instr}, m_resp());
      end
      tick();
    end
    Req_Valid = 1'b0;
    Flush     = 1'b0;
    Wr_En     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    load_words();
    test_fetch_basic();
    test_backpressure();
    test_fault();
    test_flush();
    test_write_collision();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
